slave_in_port: RTL and testbench

- Slave-side receive port of the serial bus; the far end of the master's outbound serial port.
- Deserialises the address bit stream, then (for writes) the write-data bit stream, LSB first.
- Issues one-cycle word writes to the slave memory core, with the address incrementing per word in a burst.
- For reads, hands the assembled address to the slave's outbound port via a one-cycle read request.

---
 rtl/serial_bus_pkg.sv | 23 ++
 rtl/serial_deser.sv | 48 ++++
 rtl/slave_in_port.sv | 196 +++++++++++++++++++
 tb/tb_slave_in_port.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial bus master/slave ports: receive FSM states,
// command encodings and default widths.
package serial_bus_pkg;

  localparam int unsigned DefAddrSize = 12;
  localparam int unsigned DefWordSize = 8;
  localparam int unsigned DefBurstW   = 4;

  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_B_READ  = 3'd3;
  localparam logic [2:0] S_B_WRITE = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StAddrRx,
    StDataRx,
    StMemWr,
    StRdReq,
    StDone
  } rx_state_e;

endpackage

// File: rtl/serial_deser.sv
// LSB-first deserialiser: one bit per valid cycle into data_o, full_o flags the
// cycle that consumes the final bit; data_nxt_o includes that bit already.
module serial_deser #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_i,
  input  logic             valid_i,
  input  logic             clear_i,
  output logic             full_o,
  output logic [Width-1:0] data_o,
  output logic [Width-1:0] data_nxt_o
);

  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] data_q;
  logic             shift;

  assign shift  = valid_i & ~clear_i;
  assign full_o = shift & (cnt_q == CntW'(Width - 1));

  always_comb begin
    data_nxt_o = data_q;
    cnt_d      = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (shift) begin
      data_nxt_o[cnt_q] = bit_i;
      cnt_d             = full_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_nxt_o;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/slave_in_port.sv
// Slave receive port: deserialises address then write data, issues word writes
// to the memory core or a read request to the outbound port.
module slave_in_port
  import serial_bus_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = DefAddrSize,
  parameter int unsigned WORD_SIZE = DefWordSize,
  parameter int unsigned BURST_W   = DefBurstW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 slave_sel_i,
  input  logic                 addr_bit_i,
  input  logic                 addr_valid_i,
  input  logic                 data_bit_i,
  input  logic                 data_valid_i,
  input  logic                 read_en_i,
  input  logic                 write_en_i,
  input  logic [BURST_W-1:0]   burst_len_i,
  output logic                 s_ready_o,
  output logic                 mem_we_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_wdata_o,
  output logic                 rd_req_o,
  output logic [ADDR_SIZE-1:0] rd_addr_o,
  output logic [BURST_W-1:0]   rd_len_o,
  output logic                 rx_done_o,
  output logic                 rx_abort_o
);

  rx_state_e state_q, state_d;

  logic [BURST_W-1:0]   len_q, len_d;
  logic [BURST_W-1:0]   word_cnt_q, word_cnt_d;
  logic                 s_ready_q, s_ready_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic                 rd_req_q, rd_req_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [BURST_W-1:0]   rd_len_q, rd_len_d;
  logic                 rx_done_q, rx_done_d;
  logic                 rx_abort_q, rx_abort_d;

  logic                 addr_vld, addr_clr, addr_full;
  logic [ADDR_SIZE-1:0] addr_par, addr_nxt;
  logic                 data_vld, data_clr, data_full;
  logic [WORD_SIZE-1:0] data_par, data_nxt;

  // Shifting is gated by state so qualifiers outside the receive phases are ignored.
  assign addr_vld = addr_valid_i & slave_sel_i & (state_q == StAddrRx);
  assign addr_clr = (state_q == StIdle);
  assign data_vld = data_valid_i & slave_sel_i & (state_q == StDataRx);
  assign data_clr = (state_q == StIdle) | (state_q == StMemWr);

  serial_deser #(
    .Width (ADDR_SIZE)
  ) u_addr_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_i      (addr_bit_i),
    .valid_i    (addr_vld),
    .clear_i    (addr_clr),
    .full_o     (addr_full),
    .data_o     (addr_par),
    .data_nxt_o (addr_nxt)
  );

  serial_deser #(
    .Width (WORD_SIZE)
  ) u_data_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_i      (data_bit_i),
    .valid_i    (data_vld),
    .clear_i    (data_clr),
    .full_o     (data_full),
    .data_o     (data_par),
    .data_nxt_o (data_nxt)
  );

  // Outputs are registered, so each *_d reflects the state being entered.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    s_ready_d   = 1'b1;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_req_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_len_d    = rd_len_q;
    rx_done_d   = 1'b0;
    rx_abort_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        word_cnt_d = '0;
        if (slave_sel_i) state_d = StAddrRx;
      end
      StAddrRx: begin
        if (!slave_sel_i) begin
          rx_abort_d = 1'b1;
          state_d    = StIdle;
        end else if (addr_full) begin
          len_d = (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
          if (write_en_i && !read_en_i) begin
            state_d = StDataRx;
          end else if (read_en_i && !write_en_i) begin
            state_d   = StRdReq;
            rd_req_d  = 1'b1;
            rd_addr_d = addr_nxt;
            rd_len_d  = len_d;
            s_ready_d = 1'b0;
          end else begin
            rx_abort_d = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      StDataRx: begin
        if (!slave_sel_i) begin
          rx_abort_d = 1'b1;
          state_d    = StIdle;
        end else if (data_full) begin
          state_d     = StMemWr;
          mem_we_d    = 1'b1;
          mem_wdata_d = data_nxt;
          mem_addr_d  = addr_par + ADDR_SIZE'(word_cnt_q);
          s_ready_d   = 1'b0;
        end
      end
      StMemWr: begin
        if (word_cnt_q == len_q - BURST_W'(1)) begin
          state_d   = StDone;
          rx_done_d = 1'b1;
        end else begin
          word_cnt_d = word_cnt_q + BURST_W'(1);
          state_d    = StDataRx;
        end
      end
      StRdReq: begin
        state_d   = StDone;
        rx_done_d = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      word_cnt_q  <= '0;
      s_ready_q   <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_len_q    <= '0;
      rx_done_q   <= 1'b0;
      rx_abort_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      s_ready_q   <= s_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      rd_len_q    <= rd_len_d;
      rx_done_q   <= rx_done_d;
      rx_abort_q  <= rx_abort_d;
    end
  end

  assign s_ready_o   = s_ready_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rd_req_o    = rd_req_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_len_o    = rd_len_q;
  assign rx_done_o   = rx_done_q;
  assign rx_abort_o  = rx_abort_q;

endmodule

// File: tb/tb_slave_in_port.sv
// Directed bench for slave_in_port: writes, burst wrap, read, gapped address,
// aborts, illegal command and asynchronous reset mid-transaction.
module tb_slave_in_port;

  logic        clk;
  logic        rst_n;
  logic        slave_sel;
  logic        addr_bit;
  logic        addr_valid;
  logic        data_bit;
  logic        data_valid;
  logic        read_en;
  logic        write_en;
  logic [3:0]  burst_len;
  logic        s_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        rd_req;
  logic [11:0] rd_addr;
  logic [3:0]  rd_len;
  logic        rx_done;
  logic        rx_abort;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int rdreq_cnt = 0;
  int slow_cnt = 0;
  int both_cnt = 0;

  slave_in_port u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .slave_sel_i  (slave_sel),
    .addr_bit_i   (addr_bit),
    .addr_valid_i (addr_valid),
    .data_bit_i   (data_bit),
    .data_valid_i (data_valid),
    .read_en_i    (read_en),
    .write_en_i   (write_en),
    .burst_len_i  (burst_len),
    .s_ready_o    (s_ready),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .rd_req_o     (rd_req),
    .rd_addr_o    (rd_addr),
    .rd_len_o     (rd_len),
    .rx_done_o    (rx_done),
    .rx_abort_o   (rx_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we)              we_cnt++;
      if (rx_done)             done_cnt++;
      if (rx_abort)            abort_cnt++;
      if (rd_req)              rdreq_cnt++;
      if (!s_ready)            slow_cnt++;
      if (rx_done && rx_abort) both_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_addr(input logic [11:0] a, input logic rd, input logic wr,
                           input logic [3:0] len, input bit gap);
    slave_sel = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      addr_bit   = a[i];
      addr_valid = 1'b1;
      if (i == 11) begin
        read_en   = rd;
        write_en  = wr;
        burst_len = len;
      end
      tick();
      addr_valid = 1'b0;
      read_en    = 1'b0;
      write_en   = 1'b0;
      burst_len  = 4'd0;
      if (gap) begin
        addr_bit = ~a[i];
        tick();
      end
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      data_bit   = d[i];
      data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
  endtask

  initial begin
    logic [7:0]  bdata [3];
    logic [11:0] exp_addr;
    int we0, done0, abort0, rdreq0, slow0;

    bdata[0] = 8'h11;
    bdata[1] = 8'h22;
    bdata[2] = 8'h33;

    rst_n = 1'b0; slave_sel = 1'b0; addr_bit = 1'b0; addr_valid = 1'b0;
    data_bit = 1'b0; data_valid = 1'b0; read_en = 1'b0; write_en = 1'b0; burst_len = 4'd0;
    tick();
    tick();
    check_eq("reset_s_ready", s_ready, 1'b1);
    check_eq("reset_strobes", {mem_we, rd_req, rx_done, rx_abort}, 4'h0);
    check_eq("reset_buses", {mem_addr, mem_wdata, rd_addr, rd_len}, 36'h0);
    rst_n = 1'b1;
    tick();

    // Single write
    we0 = we_cnt; done0 = done_cnt;
    send_addr(12'h0A5, 1'b0, 1'b1, 4'd1, 1'b0);
    send_bits(8'h3C, 8);
    check_eq("wr1_we", mem_we, 1'b1);
    check_eq("wr1_addr", mem_addr, 12'h0A5);
    check_eq("wr1_data", mem_wdata, 8'h3C);
    check_eq("wr1_s_ready_low", s_ready, 1'b0);
    slave_sel = 1'b0;
    tick();
    check_eq("wr1_done", {rx_done, mem_we, s_ready}, 3'b101);
    tick();
    check_eq("wr1_we_count", we_cnt - we0, 1);
    check_eq("wr1_done_count", done_cnt - done0, 1);

    // Burst write wrapping past 0xFFF
    we0 = we_cnt; slow0 = slow_cnt;
    send_addr(12'hFFE, 1'b0, 1'b1, 4'd3, 1'b0);
    for (int w = 0; w < 3; w++) begin
      send_bits(bdata[w], 8);
      exp_addr = 12'hFFE + 12'(w);
      check_eq("burst_we", mem_we, 1'b1);
      check_eq("burst_addr", mem_addr, exp_addr);
      check_eq("burst_data", mem_wdata, bdata[w]);
      if (w == 2) slave_sel = 1'b0;
      tick();
      if (w < 2) check_eq("burst_resume", {s_ready, mem_we, rx_done}, 3'b100);
      else       check_eq("burst_done", {s_ready, mem_we, rx_done}, 3'b101);
    end
    tick();
    check_eq("burst_we_count", we_cnt - we0, 3);
    check_eq("burst_s_ready_low_cycles", slow_cnt - slow0, 3);

    // Read request
    we0 = we_cnt; rdreq0 = rdreq_cnt;
    send_addr(12'h123, 1'b1, 1'b0, 4'd4, 1'b0);
    check_eq("rd_req", rd_req, 1'b1);
    check_eq("rd_addr", rd_addr, 12'h123);
    check_eq("rd_len", rd_len, 4'd4);
    slave_sel = 1'b0;
    tick();
    check_eq("rd_done", {rd_req, rx_done}, 2'b01);
    check_eq("rd_addr_held", rd_addr, 12'h123);
    tick();
    check_eq("rd_no_we", we_cnt - we0, 0);
    check_eq("rd_req_count", rdreq_cnt - rdreq0, 1);

    // Gapped address valid
    send_addr(12'h5A3, 1'b0, 1'b1, 4'd0, 1'b1);
    send_bits(8'hA5, 8);
    check_eq("gap_we", mem_we, 1'b1);
    check_eq("gap_addr", mem_addr, 12'h5A3);
    check_eq("gap_data", mem_wdata, 8'hA5);
    slave_sel = 1'b0;
    tick();
    check_eq("gap_len0_done", rx_done, 1'b1);
    tick();

    // Abort after 5 bits of the second word
    we0 = we_cnt; done0 = done_cnt; abort0 = abort_cnt;
    send_addr(12'h010, 1'b0, 1'b1, 4'd3, 1'b0);
    send_bits(8'h77, 8);
    check_eq("abort_w1_addr", mem_addr, 12'h010);
    tick();
    send_bits(8'h88, 5);
    slave_sel = 1'b0;
    tick();
    check_eq("abort_pulse", {rx_abort, rx_done, mem_we, s_ready}, 4'b1001);
    tick();
    check_eq("abort_cleared", rx_abort, 1'b0);
    check_eq("abort_we_count", we_cnt - we0, 1);
    check_eq("abort_count", abort_cnt - abort0, 1);
    check_eq("abort_no_done", done_cnt - done0, 0);

    // Illegal commands: both set, then neither set
    we0 = we_cnt; rdreq0 = rdreq_cnt; abort0 = abort_cnt;
    send_addr(12'h0F0, 1'b1, 1'b1, 4'd2, 1'b0);
    check_eq("illegal_both_abort", {rx_abort, rx_done}, 2'b10);
    slave_sel = 1'b0;
    tick();
    send_addr(12'h0F0, 1'b0, 1'b0, 4'd2, 1'b0);
    check_eq("illegal_none_abort", rx_abort, 1'b1);
    slave_sel = 1'b0;
    tick();
    tick();
    check_eq("illegal_abort_count", abort_cnt - abort0, 2);
    check_eq("illegal_no_traffic", (we_cnt - we0) + (rdreq_cnt - rdreq0), 0);

    // Asynchronous reset in the middle of DATA_RX
    we0 = we_cnt; abort0 = abort_cnt;
    send_addr(12'h200, 1'b0, 1'b1, 4'd1, 1'b0);
    send_bits(8'hFF, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_buses", {mem_addr, mem_wdata, rd_addr, rd_len}, 36'h0);
    check_eq("arst_strobes", {s_ready, mem_we, rd_req, rx_done, rx_abort}, 5'b10000);
    slave_sel = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("arst_no_strobe", (we_cnt - we0) + (abort_cnt - abort0), 0);

    send_addr(12'h7FF, 1'b0, 1'b1, 4'd1, 1'b0);
    send_bits(8'hC3, 8);
    check_eq("post_rst_wr", {mem_we, mem_addr, mem_wdata}, {1'b1, 12'h7FF, 8'hC3});
    slave_sel = 1'b0;
    tick();
    tick();

    check_eq("done_abort_exclusive", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
